// File: rtl/bcd_counter_display_pkg.sv
// Shared constants for the BCD counter and its 7-segment display driver.
// Segment patterns are active-high, ordered {a,b,c,d,e,f,g} with a as the MSB.
// Polarity inversion and the decimal point live in the top level, not here.
package bcd_counter_display_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Bit positions within the 8-bit seg bus {dp,a,b,c,d,e,f,g}
  localparam int SEG_DP_BIT = 7;
  localparam int SEG_A_BIT  = 6;
  localparam int SEG_B_BIT  = 5;
  localparam int SEG_C_BIT  = 4;
  localparam int SEG_D_BIT  = 3;
  localparam int SEG_E_BIT  = 2;
  localparam int SEG_F_BIT  = 1;
  localparam int SEG_G_BIT  = 0;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Non-BCD nibbles are forced to zero so the counter never holds an invalid digit
  function automatic logic [3:0] bcd_sanitize(input logic [3:0] d);
    return (d > BCD_MAX) ? 4'd0 : d;
  endfunction

endpackage

// File: rtl/bcd_counter_display_seg7_decoder.sv
// Combinational BCD digit to active-high a..g segment decoder.
// Out-of-range digits and an asserted blank both produce all segments off.
module seg7_decoder
  import bcd_counter_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] segs
);

  // Pattern lookup; anything outside 0..9 falls back to blank rather than all-on
  always_comb begin
    segs = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    segs = SEG_0;
        4'd1:    segs = SEG_1;
        4'd2:    segs = SEG_2;
        4'd3:    segs = SEG_3;
        4'd4:    segs = SEG_4;
        4'd5:    segs = SEG_5;
        4'd6:    segs = SEG_6;
        4'd7:    segs = SEG_7;
        4'd8:    segs = SEG_8;
        4'd9:    segs = SEG_9;
        default: segs = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with prescaled stepping, load/clear and wrap pulse,
// driving a time-multiplexed 7-segment display with leading-zero blanking.
// Display outputs are registered, so seg/an lag count by one clock.
module bcd_counter_display
  import bcd_counter_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int TICK_DIV       = 50000000,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    carry,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic          SEG_INV   = (SEG_ACTIVE_LOW != 0);
  localparam logic          AN_INV    = (AN_ACTIVE_LOW != 0);

  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  logic [CW-1:0]         inc_val;
  logic [CW-1:0]         dec_val;
  logic [CW-1:0]         load_clean;
  logic                  inc_wrap;
  logic                  dec_wrap;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  upper_zero;
  logic [SW-1:0]         scan_cnt;
  logic [IW-1:0]         scan_idx;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [6:0]            dec_segs;
  logic [NUM_DIGITS-1:0] an_onehot;
  logic [7:0]            seg_next;

  // Step strobe: prescaler sits on its last value only while enabled
  assign tick = en && (tick_cnt == TICK_LAST);

  // Ripple BCD increment/decrement and load sanitising; wrap flags end high only
  // when every digit rolled over
  always_comb begin
    inc_val    = count;
    dec_val    = count;
    load_clean = '0;
    inc_wrap   = 1'b1;
    dec_wrap   = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      load_clean[4*k +: 4] = bcd_sanitize(load_val[4*k +: 4]);
      if (inc_wrap) begin
        if (count[4*k +: 4] == BCD_MAX) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = count[4*k +: 4] + 4'd1;
          inc_wrap          = 1'b0;
        end
      end
      if (dec_wrap) begin
        if (count[4*k +: 4] == 4'd0) begin
          dec_val[4*k +: 4] = BCD_MAX;
        end else begin
          dec_val[4*k +: 4] = count[4*k +: 4] - 4'd1;
          dec_wrap          = 1'b0;
        end
      end
    end
  end

  // Counter, prescaler and carry with clear > load > tick priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      carry    <= 1'b0;
      tick_cnt <= '0;
    end else if (clear) begin
      count    <= '0;
      carry    <= 1'b0;
      tick_cnt <= '0;
    end else if (load) begin
      count    <= load_clean;
      carry    <= 1'b0;
      tick_cnt <= '0;
    end else begin
      carry <= 1'b0;
      if (en) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      end
      if (tick) begin
        if (up_dn) begin
          count <= inc_val;
          carry <= inc_wrap;
        end else begin
          count <= dec_val;
          carry <= dec_wrap;
        end
      end
    end
  end

  // Leading-zero mask: walk from the top digit down while everything seen is zero
  always_comb begin
    upper_zero = 1'b1;
    blank_vec  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero   = upper_zero && (count[4*k +: 4] == 4'd0);
      blank_vec[k] = (BLANK_LZ != 0) && (k != 0) && upper_zero;
    end
  end

  // Free-running scan timer; the digit index advances once per SCAN_DIV clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Select the digit, its blank flag and the one-hot anode for the current index
  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    an_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (scan_idx == IW'(k)) begin
        cur_digit    = count[4*k +: 4];
        cur_blank    = blank_vec[k];
        an_onehot[k] = 1'b1;
      end
    end
  end

  seg7_decoder u_decoder (
    .digit (cur_digit),
    .blank (cur_blank),
    .segs  (dec_segs)
  );

  // Apply pin polarity; dp is held at its inactive level
  always_comb begin
    seg_next             = {1'b0, dec_segs} ^ {8{SEG_INV}};
    seg_next[SEG_DP_BIT] = SEG_INV;
  end

  // an and seg share one register stage so the anode and pattern always match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= NUM_DIGITS'(1) ^ {NUM_DIGITS{AN_INV}};
      seg <= {SEG_INV, SEG_0 ^ {7{SEG_INV}}};
    end else begin
      an  <= an_onehot ^ {NUM_DIGITS{AN_INV}};
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed self-checking bench for bcd_counter_display (3 digits, fast dividers).
// Inputs change and outputs are sampled on the falling edge of clk.
// Every wait on the DUT is bounded; an expired bound shows up as a failed check.
module tb_bcd_counter_display;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        up_dn;
  logic        clear;
  logic        load;
  logic [11:0] load_val;
  logic [11:0] count;
  logic        carry;
  logic [7:0]  seg;
  logic [2:0]  an;

  int checks   = 0;
  int failures = 0;

  bcd_counter_display #(
    .NUM_DIGITS     (3),
    .TICK_DIV       (4),
    .SCAN_DIV       (2),
    .BLANK_LZ       (1),
    .SEG_ACTIVE_LOW (0),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .carry    (carry),
    .seg      (seg),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until an shows the wanted value, giving up after 12 clocks
  task automatic wait_an(input logic [2:0] want, input string tag);
    int n;
    n = 0;
    while (an !== want && n < 12) begin
      step(1);
      n++;
    end
    chk(tag, 32'(an), 32'(want));
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    up_dn    = 1'b1;
    clear    = 1'b0;
    load     = 1'b0;
    load_val = 12'h000;

    // Reset state
    step(3);
    chk("rst_count", 32'(count), 32'h000);
    chk("rst_carry", 32'(carry), 32'h0);
    chk("rst_an",    32'(an),    32'b110);
    chk("rst_seg",   32'(seg),   32'b0_1111110);

    // Rate: one step every 4 clocks after release
    rst_n = 1'b1;
    chk("rel_count", 32'(count), 32'h000);
    step(3);
    chk("rate_3clk", 32'(count), 32'h000);
    step(1);
    chk("rate_4clk", 32'(count), 32'h001);
    step(44);
    chk("rate_48clk", 32'(count), 32'h012);

    // Up wrap: 999 -> 000 with a single-cycle carry on the 4th clock
    load_val = 12'h999;
    load     = 1'b1;
    step(1);
    load = 1'b0;
    chk("wrap_loaded", 32'(count), 32'h999);
    chk("wrap_carry0", 32'(carry), 32'h0);
    for (int i = 1; i <= 6; i++) begin
      step(1);
      chk($sformatf("wrap_carry_c%0d", i), 32'(carry), (i == 4) ? 32'h1 : 32'h0);
    end
    chk("wrap_count", 32'(count), 32'h000);

    // Down: 100 -> 099, then 000 -> 999 with carry
    up_dn    = 1'b0;
    load_val = 12'h100;
    load     = 1'b1;
    step(1);
    load = 1'b0;
    step(4);
    chk("down_099", 32'(count), 32'h099);
    chk("down_nocarry", 32'(carry), 32'h0);
    load_val = 12'h000;
    load     = 1'b1;
    step(1);
    load = 1'b0;
    step(3);
    chk("borrow_pre", 32'(count), 32'h000);
    step(1);
    chk("borrow_999", 32'(count), 32'h999);
    chk("borrow_carry", 32'(carry), 32'h1);
    step(1);
    chk("borrow_carry_off", 32'(carry), 32'h0);
    chk("borrow_hold", 32'(count), 32'h999);

    // Priority: clear beats load; invalid digits load as zero
    up_dn    = 1'b1;
    load_val = 12'h123;
    clear    = 1'b1;
    load     = 1'b1;
    step(1);
    chk("clear_over_load", 32'(count), 32'h000);
    clear    = 1'b0;
    load_val = 12'h1A5;
    step(1);
    load = 1'b0;
    chk("load_invalid", 32'(count), 32'h105);

    // Prescaler freezes while disabled: 2 clocks before, 20 frozen, then 2 more to tick
    step(2);
    en = 1'b0;
    step(20);
    chk("en0_hold", 32'(count), 32'h105);
    en = 1'b1;
    step(1);
    chk("freeze_pre", 32'(count), 32'h105);
    step(1);
    chk("freeze_tick", 32'(count), 32'h106);

    // Scan and blanking with count=007
    en       = 1'b0;
    load_val = 12'h007;
    load     = 1'b1;
    step(1);
    load = 1'b0;
    step(2);
    wait_an(3'b011, "sync_d2");
    wait_an(3'b110, "sync_d0");
    for (int i = 0; i < 6; i++) begin
      logic [2:0] exp_an;
      logic [7:0] exp_seg;
      exp_an  = (i < 2) ? 3'b110 : ((i < 4) ? 3'b101 : 3'b011);
      exp_seg = (i < 2) ? 8'b0_1110000 : 8'b0_0000000;
      chk($sformatf("scan_an_c%0d", i), 32'(an), 32'(exp_an));
      chk($sformatf("scan_seg_c%0d", i), 32'(seg), 32'(exp_seg));
      step(1);
    end

    // Count=100: inner zero is displayed, not blanked
    load_val = 12'h100;
    load     = 1'b1;
    step(1);
    load = 1'b0;
    step(2);
    wait_an(3'b110, "sync100_d0");
    chk("seg100_d0", 32'(seg), 32'b0_1111110);
    wait_an(3'b101, "sync100_d1");
    chk("seg100_d1", 32'(seg), 32'b0_1111110);
    wait_an(3'b011, "sync100_d2");
    chk("seg100_d2", 32'(seg), 32'b0_0110000);

    // Async reset between edges at count=057
    load_val = 12'h057;
    load     = 1'b1;
    step(1);
    load = 1'b0;
    step(2);
    wait_an(3'b101, "sync57_d1");
    chk("pre_rst_count", 32'(count), 32'h057);
    chk("pre_rst_seg", 32'(seg), 32'b0_1011011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'h000);
    chk("arst_carry", 32'(carry), 32'h0);
    chk("arst_an",    32'(an),    32'b110);
    chk("arst_seg",   32'(seg),   32'b0_1111110);
    en    = 1'b1;
    up_dn = 1'b1;
    #1;
    rst_n = 1'b1;
    step(1);
    chk("resume_1clk", 32'(count), 32'h000);
    step(2);
    chk("resume_3clk", 32'(count), 32'h000);
    step(1);
    chk("resume_4clk", 32'(count), 32'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
